// File: rtl/simon_sequence_engine_if.sv
// Player-facing bundle of the Simon sequence engine: debounced keys and the
// start pulse go in; the display colour and game status come back out.
interface simon_sequence_engine_if #(
  parameter int NUM_KEYS = 4,
  parameter int MAX_LEN  = 16,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
);
  logic [NUM_KEYS-1:0] key;
  logic                start;
  logic [NUM_KEYS-1:0] colourOnehot;
  logic [LEN_W-1:0]    round;
  logic [LEN_W-1:0]    score;
  logic                playing;
  logic                gameover;
  logic                win;

  modport master (
    output key, start,
    input  colourOnehot, round, score, playing, gameover, win
  );

  modport slave (
    input  key, start,
    output colourOnehot, round, score, playing, gameover, win
  );
endinterface

// File: rtl/simon_sequence_engine.sv
// Simon-style colour memory game. A free-running LFSR picks a new colour for
// each round. The whole sequence is flashed back, and then the player's key
// presses are checked against it. Each press is accepted when the key is
// released, and the player has a timeout to make each press.
module simon_sequence_engine #(
  parameter int          NUM_KEYS       = 4,
  parameter int          MAX_LEN        = 16,
  parameter int          SHOW_CYCLES    = 12500000,
  parameter int          GAP_CYCLES     = 2500000,
  parameter int          TIMEOUT_CYCLES = 250000000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input logic                    clock,
  input logic                    reset,
  simon_sequence_engine_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_KEYS);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GEN,
    S_SHOW_ON,
    S_SHOW_GAP,
    S_WAIT_KEY,
    S_KEY_HELD,
    S_GAMEOVER,
    S_WIN
  } state_t;

  state_t state, next_state;

  logic [15:0]         lfsr;
  logic [IDX_W-1:0]    mem [MAX_LEN];
  logic [LEN_W-1:0]    round_q;
  logic [LEN_W-1:0]    score_q;
  logic [LEN_W-1:0]    seq_idx;
  logic [31:0]         counter;
  logic                fail;
  logic                win_phase;
  logic [NUM_KEYS-1:0] key_q;

  logic [LEN_W-1:0]    seq_idx_inc;
  logic                last_step;
  logic                show_done;
  logic                gap_done;
  logic                timeout_done;
  logic                key_any;
  logic [NUM_KEYS-1:0] expected_key;

  assign seq_idx_inc  = seq_idx + LEN_W'(1);
  assign last_step    = (seq_idx_inc == round_q);
  assign show_done    = (counter == 32'(SHOW_CYCLES - 1));
  assign gap_done     = (counter == 32'(GAP_CYCLES - 1));
  assign timeout_done = (counter == 32'(TIMEOUT_CYCLES - 1));
  assign key_any      = (bus.key != '0);
  assign expected_key = {{(NUM_KEYS-1){1'b0}}, 1'b1} << mem[seq_idx[ADDR_W-1:0]];

  // Galois LFSR keeps running in every state so that the colour chosen
  // depends on how long the player took.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end
  end

  // Sequence memory appends one LFSR-chosen colour per round. It has no
  // reset because a slot is always written before it is read.
  always_ff @(posedge clock) begin
    if (state == S_GEN) begin
      mem[round_q[ADDR_W-1:0]] <= lfsr[IDX_W-1:0];
    end
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decision for the game flow.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (bus.start) next_state = S_GEN;
      end
      S_GEN: begin
        next_state = S_SHOW_ON;
      end
      S_SHOW_ON: begin
        if (show_done) next_state = S_SHOW_GAP;
      end
      S_SHOW_GAP: begin
        if (gap_done) next_state = last_step ? S_WAIT_KEY : S_SHOW_ON;
      end
      S_WAIT_KEY: begin
        if (key_any)           next_state = S_KEY_HELD;
        else if (timeout_done) next_state = S_GAMEOVER;
      end
      S_KEY_HELD: begin
        if (!key_any) begin
          if (fail)                             next_state = S_GAMEOVER;
          else if (!last_step)                  next_state = S_WAIT_KEY;
          else if (round_q == LEN_W'(MAX_LEN))  next_state = S_WIN;
          else                                  next_state = S_GEN;
        end
      end
      S_GAMEOVER, S_WIN: begin
        if (bus.start)    next_state = S_GEN;
        else if (key_any) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Round, score, step index, delay counter and press verdict bookkeeping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      round_q   <= '0;
      score_q   <= '0;
      seq_idx   <= '0;
      counter   <= '0;
      fail      <= 1'b0;
      win_phase <= 1'b0;
      key_q     <= '0;
    end else begin
      key_q <= bus.key;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            round_q <= '0;
            score_q <= '0;
          end
        end
        S_GEN: begin
          round_q <= round_q + LEN_W'(1);
          seq_idx <= '0;
          counter <= '0;
        end
        S_SHOW_ON: begin
          counter <= show_done ? 32'd0 : counter + 32'd1;
        end
        S_SHOW_GAP: begin
          if (gap_done) begin
            counter <= '0;
            seq_idx <= last_step ? '0 : seq_idx_inc;
          end else begin
            counter <= counter + 32'd1;
          end
        end
        S_WAIT_KEY: begin
          counter <= counter + 32'd1;
          if (key_any) fail <= (bus.key != expected_key);
        end
        S_KEY_HELD: begin
          if (!key_any && !fail) begin
            counter <= '0;
            if (!last_step) begin
              seq_idx <= seq_idx_inc;
            end else begin
              score_q   <= round_q;
              win_phase <= 1'b1;
            end
          end
        end
        S_GAMEOVER, S_WIN: begin
          if (bus.start || key_any) begin
            round_q <= '0;
            score_q <= '0;
          end else if (state == S_WIN) begin
            if (show_done) begin
              counter   <= '0;
              win_phase <= ~win_phase;
            end else begin
              counter <= counter + 32'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Display colour and status flags are decoded from registered state only.
  always_comb begin
    bus.colourOnehot = '0;
    bus.playing      = 1'b0;
    bus.gameover     = 1'b0;
    bus.win          = 1'b0;
    case (state)
      S_SHOW_ON: begin
        bus.colourOnehot = expected_key;
        bus.playing      = 1'b1;
      end
      S_SHOW_GAP: begin
        bus.playing = 1'b1;
      end
      S_KEY_HELD: begin
        bus.colourOnehot = key_q;
      end
      S_GAMEOVER: begin
        bus.colourOnehot = '1;
        bus.gameover     = 1'b1;
      end
      S_WIN: begin
        bus.colourOnehot = win_phase ? '1 : '0;
        bus.win          = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.round = round_q;
  assign bus.score = score_q;

endmodule

// File: tb/tb_simon_sequence_engine.sv
// Self-checking bench for simon_sequence_engine. A reference LFSR predicts
// each colour, and a queue holds the expected sequence. The bench walks
// through a win, a wrong colour, a multi-key press, a timeout and a mid-game
// reset, using randomised delays, hold times and wrong keys.
module tb_simon_sequence_engine;

  localparam int NUM_KEYS = 4;
  localparam int MAX_LEN  = 3;
  localparam int SHOW     = 4;
  localparam int GAP      = 2;
  localparam int TIMEOUT  = 50;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  int          expSeq[$];
  logic [15:0] modelLfsr;

  simon_sequence_engine_if #(.NUM_KEYS(NUM_KEYS), .MAX_LEN(MAX_LEN)) bus ();

  simon_sequence_engine #(
    .NUM_KEYS(NUM_KEYS),
    .MAX_LEN(MAX_LEN),
    .SHOW_CYCLES(SHOW),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TIMEOUT),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clock = ~clock;

  // Reference LFSR: Galois, mask B400, shifting right once per clock.
  always @(posedge clock or posedge reset) begin
    if (reset) modelLfsr <= 16'hACE1;
    else       modelLfsr <= modelLfsr[0] ? ((modelLfsr >> 1) ^ 16'hB400) : (modelLfsr >> 1);
  end

  // Stops a hung run with a failure report.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [NUM_KEYS-1:0] k, input logic s);
    bus.key   = k;
    bus.start = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_KEYS-1:0] colourOf(input int idx);
    logic [NUM_KEYS-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".colour"},   32'(bus.colourOnehot), 32'd0);
    checkOutput({tag, ".round"},    32'(bus.round),        32'd0);
    checkOutput({tag, ".score"},    32'(bus.score),        32'd0);
    checkOutput({tag, ".playing"},  32'(bus.playing),      32'd0);
    checkOutput({tag, ".gameover"}, 32'(bus.gameover),     32'd0);
    checkOutput({tag, ".win"},      32'(bus.win),          32'd0);
  endtask

  // The bench is in the GEN cycle: record the colour the engine appends.
  task automatic captureGen();
    expSeq.push_back(int'(modelLfsr[1:0]));
  endtask

  // Pulses start and leaves the bench in the GEN cycle of a fresh game.
  task automatic startGame(input string tag);
    applyStimulus('0, 1'b1);
    tick();
    applyStimulus('0, 1'b0);
    checkOutput({tag, ".gen_round"},   32'(bus.round),   32'd0);
    checkOutput({tag, ".gen_score"},   32'(bus.score),   32'd0);
    checkOutput({tag, ".gen_playing"}, 32'(bus.playing), 32'd0);
    expSeq.delete();
    captureGen();
  endtask

  // From the GEN cycle: check the full playback and the arrival in WAIT_KEY.
  task automatic playRound(input string tag, input bit noise);
    int n;
    n = expSeq.size();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < SHOW; j++) begin
        if (noise && i == 0 && j == 1) bus.key = 4'(1 + $urandom_range(0, 14));
        if (noise && i == 0 && j == 3) bus.key = '0;
        tick();
        checkOutput($sformatf("%s.show%0d_%0d", tag, i, j), 32'(bus.colourOnehot), 32'(colourOf(expSeq[i])));
        checkOutput($sformatf("%s.showplay%0d_%0d", tag, i, j), 32'(bus.playing), 32'd1);
      end
      for (int j = 0; j < GAP; j++) begin
        tick();
        checkOutput($sformatf("%s.gap%0d_%0d", tag, i, j), 32'(bus.colourOnehot), 32'd0);
        checkOutput($sformatf("%s.gapplay%0d_%0d", tag, i, j), 32'(bus.playing), 32'd1);
      end
    end
    tick();
    checkOutput({tag, ".wait_playing"}, 32'(bus.playing),      32'd0);
    checkOutput({tag, ".wait_colour"},  32'(bus.colourOnehot), 32'd0);
    checkOutput({tag, ".wait_round"},   32'(bus.round),        32'(n));
  endtask

  // From WAIT_KEY: idle a little, press k, check the echo while held, release.
  task automatic pressKey(input string tag, input logic [NUM_KEYS-1:0] k);
    int pre;
    int hold;
    pre  = $urandom_range(0, 3);
    hold = $urandom_range(1, 4);
    for (int d = 0; d < pre; d++) begin
      tick();
      checkOutput({tag, ".idle_gameover"}, 32'(bus.gameover), 32'd0);
    end
    applyStimulus(k, 1'b0);
    for (int h = 0; h < hold; h++) begin
      tick();
      checkOutput({tag, ".echo"}, 32'(bus.colourOnehot), 32'(k));
    end
    applyStimulus('0, 1'b0);
    tick();
  endtask

  // Answers the whole current round correctly. The bench ends in GEN, or in
  // WIN after the last round.
  task automatic playCorrect(input string tag);
    int n;
    n = expSeq.size();
    for (int i = 0; i < n; i++) begin
      pressKey($sformatf("%s.press%0d", tag, i), colourOf(expSeq[i]));
    end
    checkOutput({tag, ".score"}, 32'(bus.score), 32'(n));
    if (n < MAX_LEN) captureGen();
  endtask

  initial begin
    logic [NUM_KEYS-1:0] wrongKey;
    applyStimulus('0, 1'b0);

    // Reset state
    #1;
    checkIdle("reset");
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 9; c++) begin
      tick();
      checkIdle("idle");
    end

    // Game A: play all the rounds correctly and win
    $display("[TB] game A: full win");
    startGame("A");
    for (int r = 1; r <= MAX_LEN; r++) begin
      playRound($sformatf("A.r%0d", r), 1'b0);
      playCorrect($sformatf("A.r%0d", r));
    end
    checkOutput("A.win",         32'(bus.win),          32'd1);
    checkOutput("A.win_colour0", 32'(bus.colourOnehot), 32'hF);
    for (int c = 1; c < SHOW; c++) begin
      tick();
      checkOutput("A.win_colour_on", 32'(bus.colourOnehot), 32'hF);
    end
    tick();
    checkOutput("A.win_colour_off", 32'(bus.colourOnehot), 32'd0);
    checkOutput("A.win_hold",       32'(bus.win),          32'd1);
    applyStimulus(colourOf($urandom_range(0, 3)), 1'b0);
    tick();
    checkIdle("A.to_idle");
    applyStimulus('0, 1'b0);

    // Game B: the second press of round 2 is the wrong colour
    $display("[TB] game B: wrong colour");
    repeat ($urandom_range(1, 5)) tick();
    startGame("B");
    playRound("B.r1", 1'b0);
    playCorrect("B.r1");
    playRound("B.r2", 1'b0);
    pressKey("B.ok", colourOf(expSeq[0]));
    wrongKey = colourOf((expSeq[1] + int'($urandom_range(1, 3))) % NUM_KEYS);
    pressKey("B.bad", wrongKey);
    checkOutput("B.gameover", 32'(bus.gameover),     32'd1);
    checkOutput("B.white",    32'(bus.colourOnehot), 32'hF);
    checkOutput("B.score",    32'(bus.score),        32'd1);
    checkOutput("B.win",      32'(bus.win),          32'd0);

    // Game C: restarted from GAMEOVER, and two keys at once count as a mismatch
    $display("[TB] game C: multi-key press");
    startGame("C");
    playRound("C.r1", 1'b0);
    pressKey("C.multi", 4'b0011);
    checkOutput("C.gameover", 32'(bus.gameover), 32'd1);
    checkOutput("C.score",    32'(bus.score),    32'd0);
    applyStimulus(4'b0100, 1'b0);
    tick();
    checkIdle("C.to_idle");
    applyStimulus('0, 1'b0);

    // Game D: the player times out in round 2, then start begins a new game
    $display("[TB] game D: timeout");
    startGame("D");
    playRound("D.r1", 1'b0);
    playCorrect("D.r1");
    playRound("D.r2", 1'b0);
    for (int t = 1; t < TIMEOUT; t++) begin
      tick();
      checkOutput("D.before_timeout", 32'(bus.gameover), 32'd0);
    end
    tick();
    checkOutput("D.timeout_gameover", 32'(bus.gameover),     32'd1);
    checkOutput("D.timeout_white",    32'(bus.colourOnehot), 32'hF);
    startGame("E");
    playRound("E.r1", 1'b0);
    checkOutput("E.score0", 32'(bus.score), 32'd0);
    playCorrect("E.r1");

    // Reset arrives during SHOW_ON of round 2
    $display("[TB] game E: reset during playback");
    tick();
    tick();
    checkOutput("E.pre_reset_playing", 32'(bus.playing), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    checkIdle("E.async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat ($urandom_range(2, 6)) tick();
    checkIdle("E.after_reset");
    startGame("F");
    playRound("F.r1", 1'b1);
    playCorrect("F.r1");
    checkOutput("F.round", 32'(bus.round), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
